// File: rtl/fc_argmax_if.sv
// Score stream and result handshake between an FC layer and the argmax block.
// The slave modport is the argmax side; the master side drives scores and acknowledges results.
interface fc_argmax_if #(
  parameter int SCORE_W = 12,
  parameter int IDX_W   = 4
);
  logic               score_valid;
  logic [SCORE_W-1:0] score_in;
  logic               score_ready;
  logic               result_valid;
  logic               result_ack;
  logic [IDX_W-1:0]   class_out;
  logic [SCORE_W-1:0] max_score;
  logic               busy;

  modport master (
    output score_valid, score_in, result_ack,
    input  score_ready, result_valid, class_out, max_score, busy
  );

  modport slave (
    input  score_valid, score_in, result_ack,
    output score_ready, result_valid, class_out, max_score, busy
  );
endinterface

// File: rtl/fc_argmax.sv
// Streaming argmax over N_CLASS signed scores arriving in class order.
// The winner is held in HOLD until the consumer acknowledges it; ties keep the lowest index.
module fc_argmax #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 12,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  fc_argmax_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          count;
  logic [IDX_W-1:0]          class_q;
  logic signed [SCORE_W-1:0] max_q;
  logic                      xfer;
  logic                      is_last;
  logic                      better;

  assign bus.score_ready  = (state != HOLD);
  assign bus.result_valid = (state == HOLD);
  assign bus.busy         = (state == ACCUM);
  assign bus.class_out    = class_q;
  assign bus.max_score    = max_q;

  assign xfer    = bus.score_valid && bus.score_ready;
  assign is_last = (count == LAST_IDX);
  // Both operands are signed and equal width, so the most-negative value compares without overflow.
  assign better  = $signed(bus.score_in) > max_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (xfer) state_nxt = (N_CLASS == 1) ? HOLD : ACCUM;
      ACCUM: if (xfer && is_last) state_nxt = HOLD;
      HOLD:  if (bus.result_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      class_q <= '0;
      max_q   <= '0;
    end else if (clear) begin
      count   <= '0;
      class_q <= '0;
      max_q   <= '0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          max_q   <= $signed(bus.score_in);
          class_q <= '0;
          count   <= (N_CLASS == 1) ? '0 : IDX_W'(1);
        end
        ACCUM: begin
          if (better) begin
            max_q   <= $signed(bus.score_in);
            class_q <= count;
          end
          // Counter parks at zero after the last class instead of wrapping past N_CLASS-1.
          count <= is_last ? '0 : count + IDX_W'(1);
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: one task per scenario, inline comparisons, pass/total summary.
module tb_fc_argmax;

  localparam int N_CLASS = 10;
  localparam int SCORE_W = 12;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   img[N_CLASS];

  fc_argmax_if #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) bus ();

  fc_argmax #(.N_CLASS(N_CLASS), .SCORE_W(SCORE_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Present img[first..last]; with gaps, random idle cycles precede each score.
  task automatic feed(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.score_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.score_valid = 1'b1;
      bus.score_in    = SCORE_W'(img[i]);
      @(posedge clk); #1;
    end
    bus.score_valid = 1'b0;
  endtask

  task automatic ack_result();
    bus.result_ack = 1'b1;
    @(posedge clk); #1;
    bus.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.result_valid !== 1'b0) $display("FAIL reset_result_valid got %b want 0", bus.result_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.score_ready !== 1'b1) $display("FAIL reset_score_ready got %b want 1", bus.score_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.class_out !== 4'd0) $display("FAIL reset_class_out got %0d want 0", bus.class_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.max_score !== 12'd0) $display("FAIL reset_max_score got %0d want 0", $signed(bus.max_score));
    else pass_cnt++;
  endtask

  task automatic test_basic();
    img = '{5, -3, 17, 2, 9, 0, -1, 4, 16, 3};
    ack_result();  // ack in IDLE must be ignored
    feed(0, 8, 1'b0);
    total_cnt++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL basic_before_last got rv=%b busy=%b want rv=0 busy=1", bus.result_valid, bus.busy);
    else pass_cnt++;
    feed(9, 9, 1'b0);
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.score_ready !== 1'b0)
      $display("FAIL basic_latency got rv=%b busy=%b rdy=%b want 1 0 0",
               bus.result_valid, bus.busy, bus.score_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.class_out !== 4'd2 || bus.max_score !== 12'd17)
      $display("FAIL basic_result got class=%0d max=%0d want class=2 max=17",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd2 || bus.max_score !== 12'd17)
      $display("FAIL basic_hold got rv=%b class=%0d max=%0d want 1 2 17",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
    total_cnt++;
    if (bus.result_valid !== 1'b0 || bus.score_ready !== 1'b1)
      $display("FAIL basic_ack got rv=%b rdy=%b want rv=0 rdy=1", bus.result_valid, bus.score_ready);
    else pass_cnt++;
  endtask

  task automatic test_ties();
    img = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.class_out !== 4'd0 || bus.max_score !== 12'd7)
      $display("FAIL ties_all_equal got class=%0d max=%0d want class=0 max=7",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
    // result_ack held high through ACCUM must not disturb accumulation
    img = '{0, 9, 1, 9, 1, 9, 1, 9, 1, 9};
    bus.result_ack = 1'b1;
    feed(0, 9, 1'b0);
    bus.result_ack = 1'b0;
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd1 || bus.max_score !== 12'd9)
      $display("FAIL ties_alternating got rv=%b class=%0d max=%0d want rv=1 class=1 max=9",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_min_negative();
    img = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2047};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.class_out !== 4'd9 || bus.max_score !== 12'h801)
      $display("FAIL min_neg_last got class=%0d max=%0d want class=9 max=-2047",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
    img = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.class_out !== 4'd0 || bus.max_score !== 12'h800)
      $display("FAIL min_neg_all got class=%0d max=%0d want class=0 max=-2048",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_gaps_and_hold();
    img = '{5, -3, 17, 2, 9, 0, -1, 4, 16, 3};
    feed(0, 9, 1'b1);
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd2 || bus.max_score !== 12'd17)
      $display("FAIL gaps_result got rv=%b class=%0d max=%0d want 1 2 17",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    bus.score_valid = 1'b1;
    bus.score_in    = 12'd100;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.score_ready !== 1'b0) $display("FAIL hold_ready got %b want 0", bus.score_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd2 || bus.max_score !== 12'd17)
      $display("FAIL hold_ignore_score got rv=%b class=%0d max=%0d want 1 2 17",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    bus.score_valid = 1'b0;
    ack_result();
    img = '{50, 1, 2, 3, 4, 5, 6, 7, 8, 49};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.class_out !== 4'd0 || bus.max_score !== 12'd50)
      $display("FAIL next_image_index0 got class=%0d max=%0d want class=0 max=50",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_clear();
    img = '{100, 90, 80, 70, 0, 0, 0, 0, 0, 0};
    feed(0, 3, 1'b0);
    clear           = 1'b1;
    bus.score_valid = 1'b1;
    bus.score_in    = 12'd500;
    @(posedge clk); #1;
    clear           = 1'b0;
    bus.score_valid = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.score_ready !== 1'b1)
      $display("FAIL clear_state got busy=%b rv=%b rdy=%b want 0 0 1",
               bus.busy, bus.result_valid, bus.score_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.class_out !== 4'd0 || bus.max_score !== 12'd0)
      $display("FAIL clear_outputs got class=%0d max=%0d want 0 0",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    img = '{-5, -4, -3, -2, -1, 0, 60, 1, 2, 3};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd6 || bus.max_score !== 12'd60)
      $display("FAIL clear_new_image got rv=%b class=%0d max=%0d want 1 6 60",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
  endtask

  task automatic test_async_reset();
    img = '{1, 2, 3, 40, 5, 0, 0, 0, 0, 0};
    feed(0, 4, 1'b0);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.score_ready !== 1'b1 || bus.result_valid !== 1'b0)
      $display("FAIL async_rst_state got busy=%b rdy=%b rv=%b want 0 1 0",
               bus.busy, bus.score_ready, bus.result_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.class_out !== 4'd0 || bus.max_score !== 12'd0)
      $display("FAIL async_rst_outputs got class=%0d max=%0d want 0 0",
               bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    img = '{30, -3, 17, 2, 9, 0, -1, 4, 16, 3};
    feed(0, 9, 1'b0);
    total_cnt++;
    if (bus.result_valid !== 1'b1 || bus.class_out !== 4'd0 || bus.max_score !== 12'd30)
      $display("FAIL async_rst_next_image got rv=%b class=%0d max=%0d want 1 0 30",
               bus.result_valid, bus.class_out, $signed(bus.max_score));
    else pass_cnt++;
    ack_result();
  endtask

  initial begin
    bus.score_valid = 1'b0;
    bus.score_in    = '0;
    bus.result_ack  = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_basic();
    test_ties();
    test_min_negative();
    test_gaps_and_hold();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
